// File: rtl/mem_pkg.sv
// Shared types for the memory responder.
// Access sizes, FSM states and request fault check.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        FETCH  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Reserved size, misalignment or an address beyond the RAM.
    function automatic logic is_fault(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input int          addr_w
    );
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (size == 2'd3)
            || (size == SZ_HALF && addr[0])
            || (size == SZ_WORD && addr[1:0] != 2'b00)
            || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Lane extraction for loads and lane merge for stores.
// Purely combinational, little-endian byte order.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic [31:0] mword
);

    logic [7:0]  b;
    logic [15:0] h;

    // Select the addressed lane, extend it, and build the merged word.
    always_comb begin
        b     = word[{off, 3'b000} +: 8];
        h     = word[{off[1], 4'b0000} +: 16];
        ldata = word;
        mword = word;
        case (size)
            SZ_BYTE: begin
                ldata = {{24{sign & b[7]}}, b};
                mword[{off, 3'b000} +: 8] = sdata[7:0];
            end
            SZ_HALF: begin
                ldata = {{16{sign & h[15]}}, h};
                mword[{off[1], 4'b0000} +: 16] = sdata[15:0];
            end
            default: begin
                ldata = word;
                mword = sdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with programmable wait states.
// Sub-word stores use read-modify-write on a word RAM.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [2:0]  state_out
);

    state_t              state, next;
    logic [2:0]          cnt;
    logic                r_we, r_sign;
    logic [1:0]          r_size, r_off;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata, rword;
    logic [31:0]         ldata, mword, ram_wd;
    logic                ram_we, ram_re, load_en;
    logic                accept;
    logic [31:0]         mem [2**ADDR_W];

    assign accept    = (state == IDLE) && req;
    assign busy      = (state == WAIT) || (state == ACCESS)
                    || (state == FETCH) || (state == DONE);
    assign done      = (state == DONE) || (state == ERR);
    assign fault     = (state == ERR);
    assign state_out = state;

    byte_lane_unit u_lane (
        .word  (rword),
        .off   (r_off),
        .size  (r_size),
        .sign  (r_sign),
        .sdata (r_wdata),
        .ldata (ldata),
        .mword (mword)
    );

    // State register and wait-state counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= next;
            if (accept)
                cnt <= 3'(LATENCY - 1);
            else if (state == WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
        end
    end

    // Capture the request fields when a request is accepted.
    always_ff @(posedge clock) begin
        if (accept) begin
            r_we    <= we;
            r_size  <= size;
            r_sign  <= sign;
            r_off   <= addr[1:0];
            r_idx   <= addr[ADDR_W+1:2];
            r_wdata <= wdata;
        end
    end

    // Next-state logic and RAM control strobes.
    always_comb begin
        next    = state;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        ram_wd  = r_wdata;
        load_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (req)
                    next = is_fault(size, addr, ADDR_W) ? ERR : WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0)
                    next = ACCESS;
            end
            ACCESS: begin
                if (r_we && r_size == SZ_WORD) begin
                    ram_we = 1'b1;
                    next   = DONE;
                end else begin
                    ram_re = 1'b1;
                    next   = FETCH;
                end
            end
            FETCH: begin
                if (r_we) begin
                    ram_we = 1'b1;
                    ram_wd = mword;
                end else begin
                    load_en = 1'b1;
                end
                next = DONE;
            end
            DONE:    next = IDLE;
            ERR:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Synchronous RAM; a write coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (ram_we && !reset)
            mem[r_idx] <= ram_wd;
        if (ram_re)
            rword <= mem[r_idx];
    end

    // Load result register, updated only by completed loads.
    always_ff @(posedge clock) begin
        if (reset)
            rdata <= 32'd0;
        else if (load_en)
            rdata <= ldata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder.
// Two instances: LATENCY=1 for function, LATENCY=5 for throughput.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req, we, sign;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    logic        busy1, done1, fault1;
    logic [31:0] rdata1;
    logic [2:0]  state1;
    logic        busy5, done5, fault5;
    logic [31:0] rdata5;
    logic [2:0]  state5;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_b [1024];
    logic [31:0] exp_rd;

    always #5 clock = ~clock;

    mem_responder #(.ADDR_W(8), .LATENCY(1)) u1 (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .size(size), .sign(sign), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1),
        .fault(fault1), .state_out(state1)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(5)) u5 (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .size(size), .sign(sign), .addr(addr), .wdata(wdata),
        .busy(busy5), .done(done5), .rdata(rdata5),
        .fault(fault5), .state_out(state5)
    );

    // Reference model: byte-addressed little-endian memory.
    function automatic bit m_fault(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1;
        if (a >= 32'd1024) return 1;
        if (sz == 2'd1 && a % 2 != 0) return 1;
        if (sz == 2'd2 && a % 4 != 0) return 1;
        return 0;
    endfunction

    function automatic int m_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic sg);
        logic [31:0] v;
        int n;
        n = m_bytes(sz);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v | (32'(mem_b[a + i]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] d);
        for (int i = 0; i < m_bytes(sz); i++)
            mem_b[a + i] = 8'(d >> (8 * i));
    endtask

    function automatic int m_lat(input logic [31:0] a, input logic [1:0] sz,
                                 input logic w, input int l);
        if (m_fault(a, sz)) return 1;
        if (w && sz == 2'd2) return l + 2;
        return l + 3;
    endfunction

    // Issue one request; report cycles from sampling edge to done.
    task automatic do_req(input bit sel, input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic flt, output logic [31:0] rd,
                          output logic b1);
        @(negedge clock);
        we = w; size = sz; sign = sg; addr = a; wdata = d; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        lat = 0; flt = 1'bx; rd = 'x; b1 = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (n == 1) b1 = sel ? busy5 : busy1;
            if (sel ? done5 : done1) begin
                lat = n;
                flt = sel ? fault5 : fault1;
                rd  = sel ? rdata5 : rdata1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 0; we = 0; size = 0; sign = 0;
        addr = 0; wdata = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy1, done1, fault1, state1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got b%b d%b f%b s%0d exp 0", busy1, done1, fault1, state1);
        end
        checks++;
        if (rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata got %h exp 0", rdata1);
        end
        reset = 1'b0;
        exp_rd = 0;
    endtask

    task automatic test_basic;
        int lat; logic f, b; logic [31:0] rd;
        do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, lat, f, rd, b);
        m_store(32'h10, 2'd2, 32'hDEADBEEF);
        checks++;
        if (lat !== 3 || f !== 1'b0) begin
            errors++;
            $display("FAIL sw_latency got %0d f%b exp 3 f0", lat, f);
        end
        do_req(0, 0, 2'd2, 0, 32'h10, 0, lat, f, rd, b);
        exp_rd = 32'hDEADBEEF;
        checks++;
        if (lat !== 4 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_basic got lat %0d %h exp 4 deadbeef", lat, rd);
        end
    endtask

    task automatic test_subword;
        int lat; logic f, b; logic [31:0] rd;
        do_req(0, 1, 2'd0, 0, 32'h11, 32'hAAAA_AA7F, lat, f, rd, b);
        m_store(32'h11, 2'd0, 32'hAAAA_AA7F);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL sb_latency got %0d exp 4", lat);
        end
        do_req(0, 0, 2'd2, 0, 32'h10, 0, lat, f, rd, b);
        checks++;
        if (rd !== 32'hDEAD7FEF) begin
            errors++;
            $display("FAIL sb_merge got %h exp dead7fef", rd);
        end
        do_req(0, 0, 2'd0, 1, 32'h13, 0, lat, f, rd, b);
        checks++;
        if (rd !== 32'hFFFFFFDE) begin
            errors++;
            $display("FAIL lb_sign got %h exp ffffffde", rd);
        end
        do_req(0, 0, 2'd1, 0, 32'h12, 0, lat, f, rd, b);
        exp_rd = 32'h0000DEAD;
        checks++;
        if (rd !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL lh_zero got %h exp 0000dead", rd);
        end
    endtask

    task automatic test_faults;
        int lat; logic f, b; logic [31:0] rd;
        logic [31:0] fa [4];
        logic [1:0]  fs [4];
        fa = '{32'h12, 32'h11, 32'h10, 32'h400};
        fs = '{2'd2, 2'd1, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1, fs[i], 0, fa[i], 32'h1111_1111, lat, f, rd, b);
            checks++;
            if (lat !== 1 || f !== 1'b1 || rd !== exp_rd) begin
                errors++;
                $display("FAIL fault_%0d got lat %0d f%b rd %h exp 1 f1 %h",
                         i, lat, f, rd, exp_rd);
            end
        end
        do_req(0, 0, 2'd2, 0, 32'h10, 0, lat, f, rd, b);
        exp_rd = 32'hDEAD7FEF;
        checks++;
        if (rd !== 32'hDEAD7FEF) begin
            errors++;
            $display("FAIL fault_ram got %h exp dead7fef", rd);
        end
    endtask

    task automatic test_reset_midflight;
        int lat; logic f, b; logic [31:0] rd;
        do_req(0, 1, 2'd2, 0, 32'h20, 32'hCAFEF00D, lat, f, rd, b);
        m_store(32'h20, 2'd2, 32'hCAFEF00D);
        @(negedge clock);
        we = 1; size = 2'd2; sign = 0; addr = 32'h20;
        wdata = 32'h12345678; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (state1 !== 3'd2) begin
            errors++;
            $display("FAIL mid_access got state %0d exp 2", state1);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy1 !== 1'b0 || state1 !== 3'd0 || rdata1 !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset got b%b s%0d rd %h exp 0 0 0", busy1, state1, rdata1);
        end
        reset = 1'b0;
        exp_rd = 0;
        do_req(0, 0, 2'd2, 0, 32'h20, 0, lat, f, rd, b);
        exp_rd = 32'hCAFEF00D;
        checks++;
        if (lat !== 4 || rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL mid_suppress got lat %0d %h exp 4 cafef00d", lat, rd);
        end
    endtask

    task automatic test_random;
        int lat, el; logic f, b; logic [31:0] rd, a, d;
        logic [1:0] sz; logic w, sg;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            do_req(0, 1, 2'd2, 0, 32'(4 * i), d, lat, f, rd, b);
            m_store(32'(4 * i), 2'd2, d);
        end
        for (int i = 0; i < 60; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            d  = $urandom;
            el = m_lat(a, sz, w, 1);
            do_req(0, w, sz, sg, a, d, lat, f, rd, b);
            if (!m_fault(a, sz)) begin
                if (w) m_store(a, sz, d);
                else exp_rd = m_load(a, sz, sg);
            end
            checks++;
            if (lat !== el || f !== 1'(m_fault(a, sz)) || rd !== exp_rd) begin
                errors++;
                $display("FAIL rand_%0d a=%h sz%0d we%b got lat %0d f%b %h exp %0d f%b %h",
                         i, a, sz, w, lat, f, rd, el, m_fault(a, sz), exp_rd);
            end
            if (!m_fault(a, sz)) begin
                checks++;
                if (b !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_busy_%0d got %b exp 1", i, b);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, runs, runlen, dones, bad;
        logic f, b; logic [31:0] rd;
        runs = 0; runlen = 0; dones = 0; bad = 0;
        repeat (10) @(negedge clock);
        we = 1; size = 2'd2; sign = 0; addr = 32'h40;
        wdata = 32'hA5A5_0001; req = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (k < 40) begin
                @(posedge clock);
                if (k == 39) #1 req = 1'b0;
            end
            @(negedge clock);
            if (done5) dones++;
            if (busy5) runlen++;
            else if (runlen != 0) begin
                if (runlen != 7) bad++;
                runs++;
                runlen = 0;
            end
        end
        m_store(32'h40, 2'd2, 32'hA5A5_0001);
        checks++;
        if (runs !== 5 || bad !== 0 || runlen !== 0) begin
            errors++;
            $display("FAIL b2b_busy got runs %0d bad %0d open %0d exp 5 0 0", runs, bad, runlen);
        end
        checks++;
        if (dones !== 5) begin
            errors++;
            $display("FAIL b2b_done got %0d exp 5", dones);
        end
        repeat (10) @(negedge clock);
        do_req(1, 0, 2'd2, 0, 32'h40, 0, lat, f, rd, b);
        checks++;
        if (lat !== 8 || rd !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL b2b_load got lat %0d %h exp 8 a5a50001", lat, rd);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_subword;
        test_faults;
        test_reset_midflight;
        test_random;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
